// File: rtl/floppy_pkg.sv
// floppy_pkg: shared MFM constants, types and the byte-to-cell encoder
package floppy_pkg;
  localparam logic [7:0] GAP_BYTE = 8'h4E;
  localparam logic [7:0] SYNC_BYTE = 8'hA1;
  localparam int SYNC_CLK_IDX = 5;
  typedef logic [15:0] mfm_word_t;
  typedef enum logic {IDLE, SHIFT} enc_state_e;
  function automatic mfm_word_t mfm_encode(input logic [7:0] d, input logic sync, input logic prev);
    mfm_word_t w;
    logic p;
    w = '0;
    p = prev;
    for (int i = 0; i < 8; i++) begin
      w[15-2*i] = !d[7-i] && !p && !(sync && i == SYNC_CLK_IDX);
      w[14-2*i] = d[7-i];
      p = d[7-i];
    end
    return w;
  endfunction
endpackage

// File: rtl/mfm_cell_timer.sv
// mfm_cell_timer: clock counter within a cell and cell index within a byte
module mfm_cell_timer #(
  parameter int HALF_CYC = 50,
  parameter int CW = $clog2(HALF_CYC)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          run_i,
  output logic [CW-1:0] cnt_nxt_o,
  output logic [3:0]    idx_nxt_o,
  output logic          last_o
);
  localparam logic [CW-1:0] CNT_MAX = CW'(HALF_CYC - 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0] idx_q, idx_d;
  logic wrap;
  // counters rest at zero when idle; the cell index wraps 15->0 so bytes chain with no gap
  always_comb begin
    wrap = run_i && cnt_q == CNT_MAX;
    last_o = wrap && idx_q == 4'd15;
    cnt_d = (!run_i || wrap) ? '0 : cnt_q + 1'b1;
    idx_d = !run_i ? '0 : idx_q + {3'd0, wrap};
  end
  // counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end
  assign cnt_nxt_o = cnt_d;
  assign idx_nxt_o = idx_d;
endmodule

// File: rtl/mfm_pulse_enc.sv
// mfm_pulse_enc: MFM-encodes handshaked bytes into timed active-low read pulses
module mfm_pulse_enc #(
  parameter int HALF_CYC = 50,
  parameter int PULSE_CYC = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [7:0] in_data,
  input  logic       in_sync,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       rd_data,
  output logic       busy,
  output logic       underrun
);
  import floppy_pkg::*;
  localparam int CW = $clog2(HALF_CYC);
  localparam logic [CW-1:0] PULSE_LIM = CW'(PULSE_CYC);
  enc_state_e state_q, state_d;
  logic hold_full_q, hold_full_d, hold_sync_q, hold_sync_d, prev_q, prev_d;
  logic [7:0] hold_data_q, hold_data_d;
  mfm_word_t word_q, word_d;
  logic rd_data_q, rd_data_d, busy_q, busy_d, underrun_q, underrun_d;
  logic load_idle, load_next, load_gap, load, accept, last;
  logic [CW-1:0] cnt_d;
  logic [3:0] idx_d;
  mfm_cell_timer #(.HALF_CYC(HALF_CYC), .CW(CW)) u_timer (
    .clk(clk), .rst_n(rst), .run_i(state_q == SHIFT),
    .cnt_nxt_o(cnt_d), .idx_nxt_o(idx_d), .last_o(last)
  );
  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else state_q <= state_d;
  end
  // next state: start when a byte waits, stop only at a byte boundary
  always_comb begin
    load_idle = state_q == IDLE && enable && hold_full_q;
    load_next = last && enable && hold_full_q;
    load_gap = last && enable && !hold_full_q;
    state_d = (state_q == IDLE) ? (load_idle ? SHIFT : IDLE) : ((last && !enable) ? IDLE : SHIFT);
  end
  // outputs and datapath: encode at load time, drive pulses from next-cycle cell position
  always_comb begin
    load = load_idle || load_next;
    accept = in_valid && !hold_full_q;
    hold_full_d = accept ? 1'b1 : (load ? 1'b0 : hold_full_q);
    hold_data_d = accept ? in_data : hold_data_q;
    hold_sync_d = accept ? in_sync : hold_sync_q;
    word_d = load ? mfm_encode(hold_data_q, hold_sync_q, load_next && prev_q)
           : (load_gap ? mfm_encode(GAP_BYTE, 1'b0, prev_q) : word_q);
    prev_d = load ? hold_data_q[7] : (load_gap ? GAP_BYTE[7] : prev_q);
    rd_data_d = !(state_d == SHIFT && word_d[4'd15 - idx_d] && cnt_d < PULSE_LIM);
    busy_d = state_d == SHIFT;
    underrun_d = load_gap;
  end
  // datapath and output registers; reset forces rd_data high immediately
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_full_q <= 1'b0;
      hold_data_q <= '0;
      hold_sync_q <= 1'b0;
      word_q <= '0;
      prev_q <= 1'b0;
      rd_data_q <= 1'b1;
      busy_q <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      hold_full_q <= hold_full_d;
      hold_data_q <= hold_data_d;
      hold_sync_q <= hold_sync_d;
      word_q <= word_d;
      prev_q <= prev_d;
      rd_data_q <= rd_data_d;
      busy_q <= busy_d;
      underrun_q <= underrun_d;
    end
  end
  assign in_ready = !hold_full_q;
  assign rd_data = rd_data_q;
  assign busy = busy_q;
  assign underrun = underrun_q;
endmodule

// File: tb/tb_mfm_pulse_enc.sv
// tb_mfm_pulse_enc: scoreboard bench recovering MFM cell words from rd_data pulses
module tb_mfm_pulse_enc;
  localparam int HC = 4;
  localparam int PC = 1;
  logic clk = 0, rst = 1, enable = 0, in_sync = 0, in_valid = 0;
  logic [7:0] in_data = 0;
  logic in_ready, rd_data, busy, underrun;
  typedef struct packed {logic [15:0] w; logic u;} exp_t;
  exp_t q[$];
  int checks = 0, errors = 0, bytes_seen = 0, busy_cnt = 0, lows = 0;
  logic act = 0, glitch = 0, extra_u = 0, u0 = 0;
  int m = 0;
  logic [15:0] cur = 0;

  always #5 clk = ~clk;

  mfm_pulse_enc #(.HALF_CYC(HC), .PULSE_CYC(PC)) dut (
    .clk(clk), .rst(rst), .enable(enable), .in_data(in_data), .in_sync(in_sync),
    .in_valid(in_valid), .in_ready(in_ready), .rd_data(rd_data), .busy(busy), .underrun(underrun)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  task automatic expect_word(input logic [15:0] w, input logic u);
    exp_t e;
    e.w = w;
    e.u = u;
    q.push_back(e);
  endtask

  function automatic logic sig(input int sel);
    return sel == 0 ? busy : (sel == 1 ? in_ready : underrun);
  endfunction

  task automatic wait_for(input int sel, input logic lvl, input string name);
    int n = 0;
    while (sig(sel) !== lvl && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (sig(sel) !== lvl) begin
      checks++;
      errors++;
      $display("FAIL %s timeout got %b expected %b", name, sig(sel), lvl);
    end
  endtask

  task automatic push(input logic [7:0] d, input logic s, input logic has_exp, input logic [15:0] w);
    wait_for(1, 1'b1, "push_ready");
    in_data = d;
    in_sync = s;
    in_valid = 1;
    if (has_exp) expect_word(w, 1'b0);
    @(negedge clk);
    in_valid = 0;
  endtask

  // monitor: rebuild one cell word per 16*HC busy cycles and compare against the queue head
  always @(negedge clk) begin
    if (busy) busy_cnt++;
    if (!rst) begin
      act = 0;
      q.delete();
    end else begin
      if (!act && busy) begin
        act = 1; m = 0; glitch = 0; extra_u = 0; cur = 0;
      end
      if (act) begin
        if (!busy) glitch = 1;
        if (m % HC == 0) cur[15-m/HC] = !rd_data;
        else if (!rd_data) glitch = 1;
        if (m == 0) u0 = underrun;
        else if (underrun) extra_u = 1;
        m++;
        if (m == 16 * HC) begin
          exp_t e;
          act = 0;
          bytes_seen++;
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_byte got %h expected none", cur);
          end else begin
            e = q.pop_front();
            chk("cells", {15'd0, glitch, cur}, {16'd0, e.w});
            chk("underrun", {30'd0, extra_u, u0}, {31'd0, e.u});
          end
        end
      end
    end
  end

  initial begin
    #2 rst = 0;
    repeat (3) @(negedge clk);
    chk("rst_rd_data", rd_data, 1);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_underrun", underrun, 0);
    rst = 1;
    @(negedge clk);
    // single 0x00 byte, load latency and busy length
    push(8'h00, 0, 1, 16'hAAAA);
    busy_cnt = 0;
    enable = 1;
    @(negedge clk);
    chk("load_latency_busy", busy, 1);
    chk("first_pulse", rd_data, 0);
    enable = 0;
    wait_for(0, 1'b0, "s1_idle");
    chk("busy_len", busy_cnt, 64);
    // back-to-back 0xFF bytes, second accepted while the first shifts
    push(8'hFF, 0, 1, 16'h5555);
    enable = 1;
    push(8'hFF, 0, 1, 16'h5555);
    chk("accept_while_busy", busy, 1);
    wait_for(1, 1'b1, "s2_drain");
    enable = 0;
    wait_for(0, 1'b0, "s2_idle");
    // sync mark then plain A1
    push(8'hA1, 1, 1, 16'h4489);
    enable = 1;
    push(8'hA1, 0, 1, 16'h44A9);
    wait_for(1, 1'b1, "s3_drain");
    enable = 0;
    wait_for(0, 1'b0, "s3_idle");
    // underrun: two filler bytes follow a lone 0x00
    push(8'h00, 0, 1, 16'hAAAA);
    expect_word(16'h9254, 1);
    expect_word(16'h9254, 1);
    enable = 1;
    wait_for(2, 1'b1, "s4_und1");
    @(negedge clk);
    chk("underrun_one_cycle", underrun, 0);
    wait_for(2, 1'b1, "s4_und2");
    enable = 0;
    wait_for(0, 1'b0, "s4_idle");
    // enable dropped at cell 3; a byte pushed meanwhile must stay held
    push(8'hFF, 0, 1, 16'h5555);
    enable = 1;
    wait_for(0, 1'b1, "s5_start");
    repeat (12) @(negedge clk);
    enable = 0;
    push(8'h00, 0, 1, 16'hAAAA);
    wait_for(0, 1'b0, "s5_idle");
    chk("held_in_ready", in_ready, 0);
    lows = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!rd_data || busy) lows++;
    end
    chk("idle_quiet", lows, 0);
    // held 0x00 starts a new stream from prev_bit 0 after a 0xFF
    enable = 1;
    wait_for(0, 1'b1, "s6_start");
    enable = 0;
    wait_for(0, 1'b0, "s6_idle");
    // reset at cell 7 of a 0xFF byte with another byte held
    push(8'hFF, 0, 1, 16'h5555);
    enable = 1;
    @(negedge clk);
    chk("s7_busy", busy, 1);
    push(8'h00, 0, 0, 16'h0000);
    repeat (27) @(negedge clk);
    chk("pre_rst_pulse", rd_data, 0);
    chk("pre_rst_ready", in_ready, 0);
    rst = 0;
    #1;
    chk("async_rst_rd_data", rd_data, 1);
    chk("async_rst_ready", in_ready, 1);
    chk("async_rst_busy", busy, 0);
    repeat (2) @(negedge clk);
    rst = 1;
    @(negedge clk);
    @(negedge clk);
    chk("post_rst_busy", busy, 0);
    push(8'h00, 0, 1, 16'hAAAA);
    wait_for(0, 1'b1, "s8_start");
    enable = 0;
    wait_for(0, 1'b0, "s8_idle");
    repeat (4) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    chk("bytes_seen", bytes_seen, 11);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
